// File: rtl/uart_cmd_frame_gen.sv
// uart_cmd_frame_gen: host-side command master for the UART system controller.
// Turns one high-level command into its byte frame (AA/BB/CC/DD headers), streams it
// to a UART transmitter with a valid/ready handshake, then collects up to two response
// bytes from a UART receiver and reports one assembled response word.
// Optional feature: define RSP_TIMEOUT_EN to bound the wait between response bytes
// (TIMEOUT_CYCLES); without it WAIT_RSP waits indefinitely and RSP_TIMEOUT is tied 0.
module uart_cmd_frame_gen #(
  parameter int DATA_WIDTH     = 8,
  parameter int RF_ADDR        = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_WIDTH       = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CMD_VALID,
  output logic                    CMD_READY,
  input  logic [1:0]              CMD_TYPE,
  input  logic [RF_ADDR-1:0]      CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]   CMD_WDATA,
  input  logic [DATA_WIDTH-1:0]   CMD_OP_A,
  input  logic [DATA_WIDTH-1:0]   CMD_OP_B,
  input  logic [3:0]              CMD_FUN,
  output logic [DATA_WIDTH-1:0]   TX_DATA,
  output logic                    TX_VALID,
  input  logic                    TX_READY,
  input  logic [DATA_WIDTH-1:0]   RX_DATA,
  input  logic                    RX_VALID,
  output logic [2*DATA_WIDTH-1:0] RSP_DATA,
  output logic                    RSP_VALID,
  output logic                    RSP_TIMEOUT,
  output logic                    BUSY
);

  localparam logic [1:0] CMD_RF_WR   = 2'b00;
  localparam logic [1:0] CMD_RF_RD   = 2'b01;
  localparam logic [1:0] CMD_ALU_OP  = 2'b10;
  localparam logic [1:0] CMD_ALU_NOP = 2'b11;

  // Reject a timeout that cannot be counted in TO_WIDTH bits or is too short to be useful.
  if (TIMEOUT_CYCLES < 2 || ((TIMEOUT_CYCLES - 1) >> TO_WIDTH) != 0) begin : g_bad_timeout
    $error("uart_cmd_frame_gen: TIMEOUT_CYCLES must be >= 2 and TIMEOUT_CYCLES-1 must fit in TO_WIDTH");
  end

  typedef logic [3:0][DATA_WIDTH-1:0] frame_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Byte 0 is the header; unused trailing slots stay zero.
  function automatic frame_t build_frame(
    input logic [1:0]            typ,
    input logic [RF_ADDR-1:0]    addr,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [DATA_WIDTH-1:0] op_a,
    input logic [DATA_WIDTH-1:0] op_b,
    input logic [3:0]            fun
  );
    frame_t f;
    f = '0;
    case (typ)
      CMD_RF_WR: begin
        f[0] = DATA_WIDTH'(8'hAA);
        f[1] = DATA_WIDTH'(addr);
        f[2] = wdata;
      end
      CMD_RF_RD: begin
        f[0] = DATA_WIDTH'(8'hBB);
        f[1] = DATA_WIDTH'(addr);
      end
      CMD_ALU_OP: begin
        f[0] = DATA_WIDTH'(8'hCC);
        f[1] = op_a;
        f[2] = op_b;
        f[3] = DATA_WIDTH'(fun);
      end
      CMD_ALU_NOP: begin
        f[0] = DATA_WIDTH'(8'hDD);
        f[1] = DATA_WIDTH'(fun);
      end
      default: f = '0;
    endcase
    return f;
  endfunction

  // Index of the final frame byte for each command type.
  function automatic logic [1:0] frame_last_idx(input logic [1:0] typ);
    case (typ)
      CMD_RF_WR:  return 2'd2;
      CMD_RF_RD:  return 2'd1;
      CMD_ALU_OP: return 2'd3;
      default:    return 2'd1;
    endcase
  endfunction

  // Number of response bytes the controller returns for each command type.
  function automatic logic [1:0] rsp_byte_count(input logic [1:0] typ);
    case (typ)
      CMD_RF_WR: return 2'd0;
      CMD_RF_RD: return 2'd1;
      default:   return 2'd2;
    endcase
  endfunction

  state_t                  state;
  state_t                  next_state;
  frame_t                  frame;
  logic [1:0]              byte_idx;
  logic [1:0]              last_idx;
  logic [1:0]              rsp_req;
  logic                    rsp_idx;
  logic [2*DATA_WIDTH-1:0] rsp_data;

  logic accept;
  logic tx_fire;
  logic last_byte;
  logic rx_take;
  logic rx_final;
  logic expire;

  assign accept    = CMD_VALID && (state == IDLE);
  assign tx_fire   = (state == SEND) && TX_READY;
  assign last_byte = (byte_idx == last_idx);
  assign rx_take   = (state == WAIT_RSP) && RX_VALID;
  assign rx_final  = rx_take && ({1'b0, rsp_idx} == (rsp_req - 2'd1));

  assign TX_DATA  = (state == SEND) ? frame[byte_idx] : '0;
  assign RSP_DATA = rsp_data;

`ifdef RSP_TIMEOUT_EN
  logic [TO_WIDTH-1:0] to_cnt;
  logic                tmo_flag;

  // A received byte in the expiry cycle wins, so expiry requires RX_VALID low.
  assign expire      = (state == WAIT_RSP) && !RX_VALID &&
                       (to_cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1));
  assign RSP_TIMEOUT = tmo_flag && (state == DONE);

  // Inter-byte timer: idle at zero outside WAIT_RSP, restarted by every received byte.
  always_ff @(posedge CLK) begin
    if (RST) begin
      to_cnt   <= '0;
      tmo_flag <= 1'b0;
    end else begin
      if (state != WAIT_RSP || RX_VALID) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TO_WIDTH'(1);
      end
      if (accept) begin
        tmo_flag <= 1'b0;
      end else if (expire) begin
        tmo_flag <= 1'b1;
      end
    end
  end
`else
  assign expire      = 1'b0;
  assign RSP_TIMEOUT = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and handshake outputs; write commands have no response phase.
  always_comb begin
    next_state = state;
    CMD_READY  = 1'b0;
    TX_VALID   = 1'b0;
    RSP_VALID  = 1'b0;
    BUSY       = 1'b1;
    unique case (state)
      IDLE: begin
        CMD_READY = 1'b1;
        BUSY      = 1'b0;
        if (CMD_VALID) begin
          next_state = SEND;
        end
      end
      SEND: begin
        TX_VALID = 1'b1;
        if (tx_fire && last_byte) begin
          next_state = (rsp_req == 2'd0) ? DONE : WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (rx_final || expire) begin
          next_state = DONE;
        end
      end
      DONE: begin
        RSP_VALID  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Command capture, frame byte pointer and response assembly.
  always_ff @(posedge CLK) begin
    if (RST) begin
      frame    <= '0;
      byte_idx <= 2'd0;
      last_idx <= 2'd0;
      rsp_req  <= 2'd0;
      rsp_idx  <= 1'b0;
      rsp_data <= '0;
    end else begin
      if (accept) begin
        frame    <= build_frame(CMD_TYPE, CMD_ADDR, CMD_WDATA, CMD_OP_A, CMD_OP_B, CMD_FUN);
        last_idx <= frame_last_idx(CMD_TYPE);
        rsp_req  <= rsp_byte_count(CMD_TYPE);
        byte_idx <= 2'd0;
        rsp_idx  <= 1'b0;
        rsp_data <= '0;
      end
      if (tx_fire && !last_byte) begin
        byte_idx <= byte_idx + 2'd1;
      end
      if (rx_take) begin
        if (rsp_idx) begin
          rsp_data[2*DATA_WIDTH-1:DATA_WIDTH] <= RX_DATA;
        end else begin
          rsp_data[DATA_WIDTH-1:0] <= RX_DATA;
        end
        rsp_idx <= rsp_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_frame_gen.sv
// Bench for uart_cmd_frame_gen: a vector table of commands with expected frames and
// responses, a queue scoreboard checked by a negedge monitor, and hand-written
// sequences for mid-frame reset, dropped RX bytes and the response wait/timeout.
module tb_uart_cmd_frame_gen;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic [1:0]  CMD_TYPE = 2'b00;
  logic [3:0]  CMD_ADDR = 4'h0;
  logic [7:0]  CMD_WDATA = 8'h00;
  logic [7:0]  CMD_OP_A = 8'h00;
  logic [7:0]  CMD_OP_B = 8'h00;
  logic [3:0]  CMD_FUN = 4'h0;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY = 1'b0;
  logic [7:0]  RX_DATA = 8'h00;
  logic        RX_VALID = 1'b0;
  logic [15:0] RSP_DATA;
  logic        RSP_VALID;
  logic        RSP_TIMEOUT;
  logic        BUSY;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  tx_q[$];
  logic [16:0] rsp_q[$];

  always #5 CLK = ~CLK;

  uart_cmd_frame_gen #(
    .DATA_WIDTH(8),
    .RF_ADDR(4),
    .TIMEOUT_CYCLES(100),
    .TO_WIDTH(16)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .CMD_VALID(CMD_VALID),
    .CMD_READY(CMD_READY),
    .CMD_TYPE(CMD_TYPE),
    .CMD_ADDR(CMD_ADDR),
    .CMD_WDATA(CMD_WDATA),
    .CMD_OP_A(CMD_OP_A),
    .CMD_OP_B(CMD_OP_B),
    .CMD_FUN(CMD_FUN),
    .TX_DATA(TX_DATA),
    .TX_VALID(TX_VALID),
    .TX_READY(TX_READY),
    .RX_DATA(RX_DATA),
    .RX_VALID(RX_VALID),
    .RSP_DATA(RSP_DATA),
    .RSP_VALID(RSP_VALID),
    .RSP_TIMEOUT(RSP_TIMEOUT),
    .BUSY(BUSY)
  );

  typedef struct {
    logic [1:0]      typ;
    logic [3:0]      addr;
    logic [7:0]      wdata;
    logic [7:0]      op_a;
    logic [7:0]      op_b;
    logic [3:0]      fun;
    bit              toggle;
    bit              hold;
    bit              noise;
    int              nrx;
    logic [1:0][7:0] rx;
    int              ntx;
    logic [3:0][7:0] tx;
    logic [15:0]     rsp;
    bit              tmo;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(
    input logic [1:0] typ, input logic [3:0] addr, input logic [7:0] wdata,
    input logic [7:0] op_a, input logic [7:0] op_b, input logic [3:0] fun,
    input bit toggle, input bit hold, input bit noise,
    input int nrx, input logic [7:0] r0, input logic [7:0] r1,
    input int ntx, input logic [7:0] t0, input logic [7:0] t1,
    input logic [7:0] t2, input logic [7:0] t3, input logic [15:0] rsp);
    vec_t v;
    v.typ = typ; v.addr = addr; v.wdata = wdata; v.op_a = op_a; v.op_b = op_b; v.fun = fun;
    v.toggle = toggle; v.hold = hold; v.noise = noise;
    v.nrx = nrx; v.rx[0] = r0; v.rx[1] = r1;
    v.ntx = ntx; v.tx[0] = t0; v.tx[1] = t1; v.tx[2] = t2; v.tx[3] = t3;
    v.rsp = rsp; v.tmo = 1'b0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: frame bytes on handshakes, held data on stalls, responses on RSP_VALID.
  always @(negedge CLK) begin
    if (!RST) begin
      if (TX_VALID) begin
        if (tx_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL tx_unexpected: got 0x%0h, required no byte", TX_DATA);
        end else if (TX_READY) begin
          check("tx_byte", 32'(TX_DATA), 32'(tx_q.pop_front()));
        end else begin
          check("tx_stall_hold", 32'(TX_DATA), 32'(tx_q[0]));
        end
      end
      if (RSP_VALID) begin
        if (rsp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rsp_unexpected: got 0x%0h, required no response", {RSP_TIMEOUT, RSP_DATA});
        end else begin
          check("rsp_word", 32'({RSP_TIMEOUT, RSP_DATA}), 32'(rsp_q.pop_front()));
        end
      end
    end
  end

  task automatic issue_and_send(input vec_t v);
    int cyc;
    CMD_TYPE  = v.typ;
    CMD_ADDR  = v.addr;
    CMD_WDATA = v.wdata;
    CMD_OP_A  = v.op_a;
    CMD_OP_B  = v.op_b;
    CMD_FUN   = v.fun;
    CMD_VALID = 1'b1;
    TX_READY  = !v.toggle;
    RX_VALID  = 1'b0;
    for (int i = 0; i < v.ntx; i++) tx_q.push_back(v.tx[i]);
    rsp_q.push_back({v.tmo, v.rsp});
    check("cmd_ready_idle", 32'(CMD_READY), 32'd1);
    @(posedge CLK); #1;
    if (v.hold) begin
      CMD_TYPE  = 2'b00;
      CMD_ADDR  = ~v.addr;
      CMD_WDATA = ~v.wdata;
      CMD_OP_A  = ~v.op_a;
    end else begin
      CMD_VALID = 1'b0;
    end
    check("busy_after_accept", 32'(BUSY), 32'd1);
    check("tx_valid_after_accept", 32'(TX_VALID), 32'd1);
    check("cmd_ready_busy", 32'(CMD_READY), 32'd0);
    cyc = 1;
    while (tx_q.size() != 0 && cyc < 200) begin
      if (v.toggle) TX_READY = ~TX_READY;
      RX_VALID = v.noise;
      RX_DATA  = 8'hEE;
      @(posedge CLK); #1;
      cyc++;
    end
    RX_VALID = 1'b0;
    check("tx_drained", 32'(tx_q.size()), 32'd0);
    if (!v.toggle) check("tx_back_to_back", 32'(cyc), 32'(v.ntx + 1));
    check("tx_valid_after_last", 32'(TX_VALID), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    issue_and_send(v);
    for (int j = 0; j < v.nrx; j++) begin
      RX_DATA  = v.rx[j];
      RX_VALID = 1'b1;
      @(posedge CLK); #1;
      RX_VALID = 1'b0;
      if (j < v.nrx - 1) begin
        check("rsp_early", 32'(RSP_VALID), 32'd0);
        @(posedge CLK); #1;
      end
    end
    check("rsp_latency", 32'(RSP_VALID), 32'd1);
    check("cmd_ready_done", 32'(CMD_READY), 32'd0);
    check("busy_done", 32'(BUSY), 32'd1);
    CMD_VALID = 1'b0;
    @(posedge CLK); #1;
    check("busy_idle", 32'(BUSY), 32'd0);
    check("cmd_ready_idle_again", 32'(CMD_READY), 32'd1);
    check("rsp_one_cycle", 32'(RSP_VALID), 32'd0);
    check("rsp_data_held", 32'(RSP_DATA), 32'(v.rsp));
    check("rsp_consumed", 32'(rsp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation time limit, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    int   w;
    bit   saw;

    vecs[0] = mk(2'b00, 4'h3, 8'h5A, 8'h00, 8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 8'h00,
                 3, 8'hAA, 8'h03, 8'h5A, 8'h00, 16'h0000);
    vecs[1] = mk(2'b01, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0, 0, 1, 8'h81, 8'h00,
                 2, 8'hBB, 8'h02, 8'h00, 8'h00, 16'h0081);
    vecs[2] = mk(2'b10, 4'h0, 8'h00, 8'h12, 8'h34, 4'h0, 1, 0, 1, 2, 8'h46, 8'h00,
                 4, 8'hCC, 8'h12, 8'h34, 8'h00, 16'h0046);
    vecs[3] = mk(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h1, 0, 1, 0, 2, 8'hFF, 8'h01,
                 2, 8'hDD, 8'h01, 8'h00, 8'h00, 16'h01FF);
    vecs[4] = mk(2'b01, 4'hC, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0, 0, 1, 8'h7E, 8'h00,
                 2, 8'hBB, 8'h0C, 8'h00, 8'h00, 16'h007E);
    vecs[5] = mk(2'b00, 4'hF, 8'h00, 8'h00, 8'h00, 4'h0, 1, 0, 0, 0, 8'h00, 8'h00,
                 3, 8'hAA, 8'h0F, 8'h00, 8'h00, 16'h0000);
    vecs[6] = mk(2'b10, 4'h0, 8'h00, 8'hFF, 8'h80, 4'hF, 0, 0, 0, 2, 8'hA5, 8'h5A,
                 4, 8'hCC, 8'hFF, 8'h80, 8'h0F, 16'h5AA5);
    vecs[7] = mk(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'hF, 1, 0, 0, 2, 8'h00, 8'h80,
                 2, 8'hDD, 8'h0F, 8'h00, 8'h00, 16'h8000);

    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    check("rst_cmd_ready", 32'(CMD_READY), 32'd1);
    check("rst_tx_valid", 32'(TX_VALID), 32'd0);
    check("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    check("rst_rsp_timeout", 32'(RSP_TIMEOUT), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_tx_data", 32'(TX_DATA), 32'd0);
    check("rst_rsp_data", 32'(RSP_DATA), 32'd0);

    // Response bytes arriving while idle must be discarded.
    RX_DATA  = 8'hEE;
    RX_VALID = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RX_VALID = 1'b0;
    check("rx_idle_busy", 32'(BUSY), 32'd0);
    check("rx_idle_rsp_data", 32'(RSP_DATA), 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset after the first byte of a write frame aborts it without a response.
    CMD_TYPE  = 2'b00;
    CMD_ADDR  = 4'h3;
    CMD_WDATA = 8'h5A;
    CMD_VALID = 1'b1;
    TX_READY  = 1'b1;
    tx_q.push_back(8'hAA);
    tx_q.push_back(8'h03);
    tx_q.push_back(8'h5A);
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    @(posedge CLK); #1;
    check("rst_mid_second_byte", 32'(TX_DATA), 32'h03);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    tx_q.delete();
    rsp_q.delete();
    check("rst_mid_tx_valid", 32'(TX_VALID), 32'd0);
    check("rst_mid_busy", 32'(BUSY), 32'd0);
    check("rst_mid_cmd_ready", 32'(CMD_READY), 32'd1);
    check("rst_mid_tx_data", 32'(TX_DATA), 32'd0);
    check("rst_mid_rsp_data", 32'(RSP_DATA), 32'd0);
    saw = 1'b0;
    repeat (5) begin
      @(posedge CLK); #1;
      if (RSP_VALID) saw = 1'b1;
    end
    check("rst_mid_no_rsp", 32'(saw), 32'd0);
    run_vec(vecs[2]);

`ifdef RSP_TIMEOUT_EN
    // No response at all: 100 WAIT_RSP cycles, then a timed-out completion.
    v = mk(2'b01, 4'h5, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 8'h00,
           2, 8'hBB, 8'h05, 8'h00, 8'h00, 16'h0000);
    v.tmo = 1'b1;
    issue_and_send(v);
    w = 0;
    while (!RSP_VALID && w < 1000) begin
      @(posedge CLK); #1;
      w++;
    end
    check("timeout_wait_cycles", 32'(w), 32'd100);
    check("timeout_flag", 32'(RSP_TIMEOUT), 32'd1);
    @(posedge CLK); #1;
    check("timeout_flag_cleared", 32'(RSP_TIMEOUT), 32'd0);
    check("timeout_idle", 32'(BUSY), 32'd0);

    // Byte in the last WAIT_RSP cycle beats the timeout.
    v = mk(2'b01, 4'h1, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0, 0, 1, 8'h33, 8'h00,
           2, 8'hBB, 8'h01, 8'h00, 8'h00, 16'h0033);
    issue_and_send(v);
    repeat (99) begin
      @(posedge CLK); #1;
    end
    check("expiry_race_no_early_rsp", 32'(RSP_VALID), 32'd0);
    RX_DATA  = 8'h33;
    RX_VALID = 1'b1;
    @(posedge CLK); #1;
    RX_VALID = 1'b0;
    check("expiry_race_rsp", 32'(RSP_VALID), 32'd1);
    check("expiry_race_no_timeout", 32'(RSP_TIMEOUT), 32'd0);
    @(posedge CLK); #1;

    // One of two ALU bytes arrives: timeout reports the partial word.
    v = mk(2'b10, 4'h0, 8'h00, 8'h01, 8'h02, 4'h3, 0, 0, 0, 0, 8'h00, 8'h00,
           4, 8'hCC, 8'h01, 8'h02, 8'h03, 16'h0077);
    v.tmo = 1'b1;
    issue_and_send(v);
    repeat (10) begin
      @(posedge CLK); #1;
    end
    RX_DATA  = 8'h77;
    RX_VALID = 1'b1;
    @(posedge CLK); #1;
    RX_VALID = 1'b0;
    w = 0;
    while (!RSP_VALID && w < 1000) begin
      @(posedge CLK); #1;
      w++;
    end
    check("partial_timeout_cycles", 32'(w), 32'd100);
    check("partial_timeout_flag", 32'(RSP_TIMEOUT), 32'd1);
    @(posedge CLK); #1;
`else
    // Without the timeout the block waits for the response however long it takes.
    v = mk(2'b01, 4'h9, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0, 0, 1, 8'h3C, 8'h00,
           2, 8'hBB, 8'h09, 8'h00, 8'h00, 16'h003C);
    issue_and_send(v);
    saw = 1'b0;
    repeat (300) begin
      @(posedge CLK); #1;
      if (RSP_VALID || RSP_TIMEOUT) saw = 1'b1;
    end
    check("wait_indefinite_no_rsp", 32'(saw), 32'd0);
    check("wait_indefinite_busy", 32'(BUSY), 32'd1);
    RX_DATA  = 8'h3C;
    RX_VALID = 1'b1;
    @(posedge CLK); #1;
    RX_VALID = 1'b0;
    check("wait_indefinite_rsp", 32'(RSP_VALID), 32'd1);
    check("wait_indefinite_no_timeout", 32'(RSP_TIMEOUT), 32'd0);
    @(posedge CLK); #1;
    w = 0;
`endif

    repeat (3) begin
      @(posedge CLK); #1;
    end
    check("end_tx_queue_empty", 32'(tx_q.size()), 32'd0);
    check("end_rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
    check("end_idle", 32'(BUSY), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
